base_rsp_route: RTL and testbench

- Return-path companion to the fixed-priority grant encoder. It records the one-hot grant issued to each requester, in issue order.
- It steers the downstream response stream, which may be multi-beat, back to the requester that owns the oldest outstanding grant.
- It sits between a shared response channel and ways per-requester response ports, and tracks up to depth outstanding grants.

---
 rtl/base_onehot_enc.sv | 43 ++++
 rtl/base_rsp_route.sv | 148 ++++++++++++++
 tb/tb_base_rsp_route.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/base_onehot_enc.sv
// ---------------------------------------------------------------------------
// base_onehot_enc
//   Combinational one-hot to binary encoder. Reports the index of the
//   lowest-numbered set bit, plus flags for "no bit set" and "more than one
//   bit set". Index 0 is the highest-priority position. Reusable by any
//   arbiter that needs to turn a grant vector back into an index.
//
// Ports:
//   i_oh     in  [0:ways-1]  one-hot (ideally) input vector
//   o_idx    out [iw-1:0]    index of the lowest-numbered set bit (0 if none)
//   o_none   out 1           no bit of i_oh is set
//   o_multi  out 1           more than one bit of i_oh is set
// ---------------------------------------------------------------------------
module base_onehot_enc #(
    parameter int ways = 4,
    parameter int iw   = (ways > 1) ? $clog2(ways) : 1
) (
    input  logic [0:ways-1] i_oh,
    output logic [iw-1:0]   o_idx,
    output logic            o_none,
    output logic            o_multi
);

    // Scan from the highest index down so the lowest set index wins last.
    always_comb begin
        o_idx  = '0;
        o_none = 1'b1;
        for (int k = ways - 1; k >= 0; k--) begin
            if (i_oh[k]) begin
                o_idx  = iw'(k);
                o_none = 1'b0;
            end else begin
                o_idx  = o_idx;
                o_none = o_none;
            end
        end
    end

    // Clearing the lowest set bit leaves something behind only if two or
    // more bits were set; this holds regardless of bit-ordering direction.
    assign o_multi = ((i_oh & (i_oh - ways'(1))) != '0);

endmodule

// File: rtl/base_rsp_route.sv
// ---------------------------------------------------------------------------
// base_rsp_route
//   Return-path companion to a fixed-priority grant encoder. Each accepted
//   grant records the granted requester index in a small FIFO, in issue
//   order. The shared (possibly multi-beat) response stream is steered to the
//   requester at the FIFO head; the entry is retired on the last beat.
//
// Ports:
//   clk       in   clock
//   reset     in   asynchronous active-high reset
//   i_gnt_v   in   grant event valid
//   i_gnt_r   out  grant accept (outstanding count < depth)
//   i_gnt_oh  in   [0:ways-1] one-hot grant vector
//   i_rsp_v   in   shared response valid
//   i_rsp_r   out  shared response ready
//   i_rsp_d   in   [0:width-1] response data
//   i_rsp_e   in   last beat of a response
//   o_rsp_v   out  [0:ways-1] per-requester response valid (at most one set)
//   o_rsp_r   in   [0:ways-1] per-requester ready
//   o_rsp_d   out  [0:width-1] response data, broadcast
//   o_rsp_e   out  last-beat flag, broadcast
//   o_cnt     out  [0:cw-1] outstanding grant count
//   o_err     out  {bit1: orphan response, bit0: bad grant vector}, pulses
// ---------------------------------------------------------------------------
module base_rsp_route #(
    parameter int ways  = 4,
    parameter int width = 64,
    parameter int depth = 8,
    parameter int iw    = (ways > 1) ? $clog2(ways) : 1,
    parameter int cw    = $clog2(depth + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_gnt_v,
    output logic             i_gnt_r,
    input  logic [0:ways-1]  i_gnt_oh,
    input  logic             i_rsp_v,
    output logic             i_rsp_r,
    input  logic [0:width-1] i_rsp_d,
    input  logic             i_rsp_e,
    output logic [0:ways-1]  o_rsp_v,
    input  logic [0:ways-1]  o_rsp_r,
    output logic [0:width-1] o_rsp_d,
    output logic             o_rsp_e,
    output logic [0:cw-1]    o_cnt,
    output logic [1:0]       o_err
);

    localparam int pw = $clog2(depth);

    logic [iw-1:0] r_fifo [0:depth-1];
    logic [pw-1:0] r_wr_ptr;
    logic [pw-1:0] r_rd_ptr;
    logic [cw-1:0] r_cnt;
    logic [1:0]    r_err;

    logic [iw-1:0] w_idx;
    logic          w_none;
    logic          w_multi;
    logic [iw-1:0] w_head;
    logic          w_nonempty;
    logic          w_push;
    logic          w_pop;

    base_onehot_enc #(
        .ways (ways),
        .iw   (iw)
    ) u_enc (
        .i_oh    (i_gnt_oh),
        .o_idx   (w_idx),
        .o_none  (w_none),
        .o_multi (w_multi)
    );

    assign w_head     = r_fifo[r_rd_ptr];
    assign w_nonempty = (r_cnt != '0);

    // Accept depends only on the registered count, so a same-cycle pop
    // never opens room for a push.
    assign i_gnt_r = (r_cnt != cw'(depth));
    assign w_push  = i_gnt_v & i_gnt_r & ~w_none;

    assign i_rsp_r = w_nonempty & o_rsp_r[w_head];
    assign w_pop   = i_rsp_v & i_rsp_r & i_rsp_e;

    assign o_rsp_d = i_rsp_d;
    assign o_rsp_e = i_rsp_e;
    assign o_cnt   = r_cnt;
    assign o_err   = r_err;

    // Steer the shared valid to the requester owning the head entry.
    always_comb begin
        o_rsp_v = '0;
        for (int k = 0; k < ways; k++) begin
            o_rsp_v[k] = i_rsp_v & w_nonempty & (w_head == iw'(k));
        end
    end

    // Grant FIFO storage: write the encoded index at the tail on push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < depth; i++) begin
                r_fifo[i] <= '0;
            end
        end else if (w_push) begin
            r_fifo[r_wr_ptr] <= w_idx;
        end else begin
            r_fifo[r_wr_ptr] <= r_fifo[r_wr_ptr];
        end
    end

    // Pointers and count; pointers are log2(depth) bits and wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + pw'(1);
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + pw'(1);
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + cw'(1);
                2'b01:   r_cnt <= r_cnt - cw'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Error pulses: bad grant vector and response with nothing outstanding;
    // they repeat every cycle the condition holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 2'b00;
        end else begin
            r_err[0] <= i_gnt_v & (w_none | w_multi);
            r_err[1] <= i_rsp_v & ~w_nonempty;
        end
    end

endmodule

// File: tb/tb_base_rsp_route.sv
module tb_base_rsp_route;

    localparam int W  = 4;
    localparam int DW = 64;
    localparam int D  = 8;
    localparam int CW = 4;

    logic          clk;
    logic          reset;
    logic          gnt_v;
    logic          gnt_r;
    logic [0:W-1]  gnt_oh;
    logic          rsp_v;
    logic          rsp_r;
    logic [0:DW-1] rsp_d;
    logic          rsp_e;
    logic [0:W-1]  out_v;
    logic [0:W-1]  out_r;
    logic [0:DW-1] out_d;
    logic          out_e;
    logic [0:CW-1] cnt;
    logic [1:0]    err;

    int checks   = 0;
    int failures = 0;
    int beats2   = 0;
    int base2;

    base_rsp_route #(.ways(W), .width(DW), .depth(D)) dut (
        .clk      (clk),
        .reset    (reset),
        .i_gnt_v  (gnt_v),
        .i_gnt_r  (gnt_r),
        .i_gnt_oh (gnt_oh),
        .i_rsp_v  (rsp_v),
        .i_rsp_r  (rsp_r),
        .i_rsp_d  (rsp_d),
        .i_rsp_e  (rsp_e),
        .o_rsp_v  (out_v),
        .o_rsp_r  (out_r),
        .o_rsp_d  (out_d),
        .o_rsp_e  (out_e),
        .o_cnt    (cnt),
        .o_err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count beats actually delivered to way 2.
    always @(posedge clk) begin
        if (!reset && rsp_v && rsp_r && out_v[2]) beats2 <= beats2 + 1;
    end

    function automatic logic [0:W-1] oh(input int k);
        logic [0:W-1] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int exp_h [0:7];
        exp_h = '{1, 2, 3, 0, 1, 2, 3, 1};
        reset = 1'b1; gnt_v = 1'b0; gnt_oh = '0; rsp_v = 1'b0;
        rsp_d = '0; rsp_e = 1'b0; out_r = '1;
        tick; tick;
        chk("rst_cnt", 64'(cnt), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_rsp_r", 64'(rsp_r), 64'd0);
        chk("rst_out_v", 64'(out_v), 64'd0);
        chk("rst_gnt_r", 64'(gnt_r), 64'd1);
        reset = 1'b0;
        tick;

        // In-order single-beat routing: grants to ways 1, 3, 0.
        gnt_v = 1'b1; gnt_oh = oh(1); tick;
        gnt_oh = oh(3); tick;
        gnt_oh = oh(0); tick;
        gnt_v = 1'b0; gnt_oh = '0;
        chk("t1_cnt3", 64'(cnt), 64'd3);
        rsp_v = 1'b1; rsp_e = 1'b1; rsp_d = 64'hD1; #1;
        chk("t1_v1", 64'(out_v), 64'(oh(1)));
        chk("t1_d1", 64'(out_d), 64'hD1);
        chk("t1_r1", 64'(rsp_r), 64'd1);
        tick;
        chk("t1_cnt2", 64'(cnt), 64'd2);
        rsp_d = 64'hD2; #1;
        chk("t1_v2", 64'(out_v), 64'(oh(3)));
        chk("t1_d2", 64'(out_d), 64'hD2);
        tick;
        chk("t1_cnt1", 64'(cnt), 64'd1);
        rsp_d = 64'hD3; #1;
        chk("t1_v3", 64'(out_v), 64'(oh(0)));
        chk("t1_d3", 64'(out_d), 64'hD3);
        tick;
        rsp_v = 1'b0; rsp_e = 1'b0;
        chk("t1_cnt0", 64'(cnt), 64'd0);
        chk("t1_err", 64'(err), 64'd0);

        // Four-beat burst to way 2 with a two-cycle stall mid-burst.
        gnt_v = 1'b1; gnt_oh = oh(2); tick;
        gnt_v = 1'b0; gnt_oh = '0;
        base2 = beats2;
        rsp_v = 1'b1; rsp_e = 1'b0; rsp_d = 64'hB1; #1;
        chk("t2_v", 64'(out_v), 64'(oh(2)));
        chk("t2_r", 64'(rsp_r), 64'd1);
        tick;
        rsp_d = 64'hB2; tick;
        rsp_d = 64'hB3; out_r = 4'b1111 & ~oh(2); #1;
        chk("t2_stall_r", 64'(rsp_r), 64'd0);
        chk("t2_stall_v", 64'(out_v), 64'(oh(2)));
        tick; tick;
        chk("t2_cnt_hold", 64'(cnt), 64'd1);
        out_r = '1; #1;
        chk("t2_resume_r", 64'(rsp_r), 64'd1);
        tick;
        chk("t2_cnt_b3", 64'(cnt), 64'd1);
        rsp_d = 64'hB4; rsp_e = 1'b1; #1;
        chk("t2_e", 64'(out_e), 64'd1);
        chk("t2_d4", 64'(out_d), 64'hB4);
        tick;
        rsp_v = 1'b0; rsp_e = 1'b0;
        chk("t2_cnt0", 64'(cnt), 64'd0);
        #1;
        chk("t2_beats", 64'(beats2 - base2), 64'd4);

        // Fill to depth; a push alongside a pop at full is refused.
        gnt_v = 1'b1;
        for (int k = 0; k < 8; k++) begin
            gnt_oh = oh(k % 4); tick;
        end
        chk("t3_cnt8", 64'(cnt), 64'd8);
        chk("t3_gnt_r0", 64'(gnt_r), 64'd0);
        gnt_oh = oh(1); rsp_v = 1'b1; rsp_e = 1'b1; #1;
        chk("t3_pop_r", 64'(rsp_r), 64'd1);
        tick;
        rsp_v = 1'b0; rsp_e = 1'b0;
        chk("t3_cnt7", 64'(cnt), 64'd7);
        chk("t3_gnt_r1", 64'(gnt_r), 64'd1);
        tick;
        gnt_v = 1'b0; gnt_oh = '0;
        chk("t3_cnt8b", 64'(cnt), 64'd8);
        rsp_v = 1'b1; rsp_e = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("t3_drain%0d", i), 64'(out_v), 64'(oh(exp_h[i])));
            tick;
        end
        rsp_v = 1'b0; rsp_e = 1'b0;
        chk("t3_cnt0", 64'(cnt), 64'd0);

        // Bad grant vectors.
        gnt_v = 1'b1; gnt_oh = '0; tick;
        gnt_v = 1'b0;
        chk("t4_zero_cnt", 64'(cnt), 64'd0);
        chk("t4_zero_err", 64'(err), 64'd1);
        tick;
        chk("t4_err_clr", 64'(err), 64'd0);
        gnt_v = 1'b1; gnt_oh = oh(1) | oh(2); tick;
        gnt_v = 1'b0; gnt_oh = '0;
        chk("t4_multi_cnt", 64'(cnt), 64'd1);
        chk("t4_multi_err", 64'(err), 64'd1);
        rsp_v = 1'b1; rsp_e = 1'b1; #1;
        chk("t4_multi_v", 64'(out_v), 64'(oh(1)));
        tick;
        rsp_v = 1'b0; rsp_e = 1'b0;
        chk("t4_cnt0", 64'(cnt), 64'd0);
        chk("t4_err0", 64'(err), 64'd0);

        // Orphan responses for three cycles; a grant in the third steers the fourth.
        rsp_v = 1'b1; rsp_e = 1'b1; #1;
        chk("t5_r0", 64'(rsp_r), 64'd0);
        chk("t5_v0", 64'(out_v), 64'd0);
        tick;
        chk("t5_err_c1", 64'(err), 64'd2);
        tick;
        chk("t5_err_c2", 64'(err), 64'd2);
        gnt_v = 1'b1; gnt_oh = oh(3); #1;
        chk("t5_r_c3", 64'(rsp_r), 64'd0);
        tick;
        gnt_v = 1'b0; gnt_oh = '0;
        chk("t5_err_c3", 64'(err), 64'd2);
        chk("t5_cnt1", 64'(cnt), 64'd1);
        #1;
        chk("t5_v_c4", 64'(out_v), 64'(oh(3)));
        chk("t5_r_c4", 64'(rsp_r), 64'd1);
        tick;
        rsp_v = 1'b0; rsp_e = 1'b0;
        chk("t5_cnt0", 64'(cnt), 64'd0);
        chk("t5_err0", 64'(err), 64'd0);

        // Reset in the middle of a burst with five outstanding grants.
        gnt_v = 1'b1;
        for (int k = 0; k < 5; k++) begin
            gnt_oh = oh(k % 4); tick;
        end
        gnt_v = 1'b0; gnt_oh = '0;
        chk("t6_cnt5", 64'(cnt), 64'd5);
        rsp_v = 1'b1; rsp_e = 1'b0; rsp_d = 64'hC1; tick;
        rsp_d = 64'hC2; #1;
        reset = 1'b1; #1;
        chk("t6_rst_cnt", 64'(cnt), 64'd0);
        chk("t6_rst_v", 64'(out_v), 64'd0);
        chk("t6_rst_r", 64'(rsp_r), 64'd0);
        tick;
        reset = 1'b0; rsp_v = 1'b0;
        tick;
        chk("t6_err0", 64'(err), 64'd0);
        gnt_v = 1'b1; gnt_oh = oh(2); tick;
        gnt_v = 1'b0; gnt_oh = '0;
        rsp_v = 1'b1; rsp_e = 1'b1; rsp_d = 64'hE1; #1;
        chk("t6_post_v", 64'(out_v), 64'(oh(2)));
        chk("t6_post_r", 64'(rsp_r), 64'd1);
        tick;
        rsp_v = 1'b0; rsp_e = 1'b0;
        chk("t6_post_cnt", 64'(cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
